// File: rtl/alu_issue_queue.sv
// alu_issue_queue: in-order ALU issue queue with a register busy-bit scoreboard.
// The head op is held until its register sources and destination are free.
`default_nettype none

module alu_issue_queue #(
  parameter int DEPTH = 4,
  parameter int CW    = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        enq_valid,
  output logic        enq_ready,
  input  logic [4:0]  enq_rs1,
  input  logic [4:0]  enq_rs2,
  input  logic [4:0]  enq_rd,
  input  logic        enq_rd_we,
  input  logic [1:0]  enq_aluop1_type,
  input  logic [1:0]  enq_aluop2_type,
  input  logic [31:0] enq_imm,
  input  logic [14:0] enq_pc,
  input  logic [4:0]  enq_aluctl,
  output logic        iss_valid,
  input  logic        iss_ready,
  output logic [4:0]  iss_rs1,
  output logic [4:0]  iss_rs2,
  output logic [4:0]  iss_rd,
  output logic        iss_rd_we,
  output logic [1:0]  iss_aluop1_type,
  output logic [1:0]  iss_aluop2_type,
  output logic [31:0] iss_imm,
  output logic [14:0] iss_pc,
  output logic [4:0]  iss_aluctl,
  input  logic        wb_valid,
  input  logic [4:0]  wb_rd,
  output logic [CW-1:0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int EW = 5 + 5 + 5 + 1 + 2 + 2 + 32 + 15 + 5;
  // Operand encoding: REG = 0, IMM = 1, PC = 2; only REG creates a dependency.
  localparam logic [1:0] OP_TYPE_REG = 2'd0;

  logic [EW-1:0]   mem_q [DEPTH];
  logic [AW:0]     head_q, head_d;
  logic [AW:0]     tail_q, tail_d;
  logic [CW-1:0]   count_q, count_d;
  logic [31:1]     busy_q, busy_d;

  logic [EW-1:0]   w_head;
  logic [31:0]     w_eff_busy;
  logic            w_empty;
  logic            w_full;
  logic            w_hazard;
  logic            w_enq_fire;
  logic            w_iss_fire;

  assign w_empty = (head_q == tail_q);
  assign w_full  = (head_q[AW-1:0] == tail_q[AW-1:0]) && (head_q[AW] != tail_q[AW]);

  assign w_head = mem_q[head_q[AW-1:0]];
  assign {iss_rs1, iss_rs2, iss_rd, iss_rd_we, iss_aluop1_type, iss_aluop2_type,
          iss_imm, iss_pc, iss_aluctl} = w_head;

  // A same-cycle writeback releases its register before the hazard check.
  always_comb begin
    w_eff_busy = '0;
    for (int r = 1; r < 32; r++) begin
      w_eff_busy[r] = busy_q[r] & ~(wb_valid && (wb_rd == 5'(r)));
    end
  end

  assign w_hazard = ((iss_aluop1_type == OP_TYPE_REG) && w_eff_busy[iss_rs1]) ||
                    ((iss_aluop2_type == OP_TYPE_REG) && w_eff_busy[iss_rs2]) ||
                    (iss_rd_we && (iss_rd != 5'd0) && w_eff_busy[iss_rd]);

  assign enq_ready  = ~w_full;
  assign iss_valid  = ~w_empty & ~w_hazard & ~flush;
  assign w_enq_fire = enq_valid & enq_ready & ~flush;
  assign w_iss_fire = iss_valid & iss_ready;
  assign count      = count_q;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (w_enq_fire) tail_d = tail_q + 1'b1;
      if (w_iss_fire) head_d = head_q + 1'b1;
      if (w_enq_fire && !w_iss_fire) count_d = count_q + 1'b1;
      else if (!w_enq_fire && w_iss_fire) count_d = count_q - 1'b1;
    end
  end

  // Issue sets after writeback clears so a same-register collision stays busy.
  always_comb begin
    busy_d = busy_q;
    if (wb_valid && (wb_rd != 5'd0)) busy_d[wb_rd] = 1'b0;
    if (w_iss_fire && iss_rd_we && (iss_rd != 5'd0)) busy_d[iss_rd] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      busy_q  <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      busy_q  <= busy_d;
    end
  end

  always_ff @(posedge clk) begin
    if (w_enq_fire) begin
      mem_q[tail_q[AW-1:0]] <= {enq_rs1, enq_rs2, enq_rd, enq_rd_we, enq_aluop1_type,
                                enq_aluop2_type, enq_imm, enq_pc, enq_aluctl};
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_alu_issue_queue.sv
// tb_alu_issue_queue: scoreboard bench for alu_issue_queue; expected issue
// records are queued as ops are offered and compared as the DUT issues them.
`default_nettype none

module tb_alu_issue_queue;

  localparam int DEPTH = 4;
  localparam int CW    = 3;
  localparam logic [1:0] T_REG = 2'd0;
  localparam logic [1:0] T_IMM = 2'd1;
  localparam logic [1:0] T_PC  = 2'd2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        enq_valid = 1'b0;
  logic        enq_ready;
  logic [4:0]  enq_rs1 = '0, enq_rs2 = '0, enq_rd = '0, enq_aluctl = '0;
  logic        enq_rd_we = 1'b0;
  logic [1:0]  enq_aluop1_type = '0, enq_aluop2_type = '0;
  logic [31:0] enq_imm = '0;
  logic [14:0] enq_pc = '0;
  logic        iss_valid;
  logic        iss_ready = 1'b0;
  logic [4:0]  iss_rs1, iss_rs2, iss_rd, iss_aluctl;
  logic        iss_rd_we;
  logic [1:0]  iss_aluop1_type, iss_aluop2_type;
  logic [31:0] iss_imm;
  logic [14:0] iss_pc;
  logic        wb_valid = 1'b0;
  logic [4:0]  wb_rd = '0;
  logic [CW-1:0] count;

  typedef struct {
    logic [14:0] pc;
    logic [31:0] imm;
    logic [4:0]  rd;
    logic [4:0]  aluctl;
  } exp_t;

  exp_t sb[$];
  int   model_cnt = 0;
  int   errors = 0;
  int   checks = 0;

  alu_issue_queue #(.DEPTH(DEPTH), .CW(CW)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .enq_valid(enq_valid), .enq_ready(enq_ready),
    .enq_rs1(enq_rs1), .enq_rs2(enq_rs2), .enq_rd(enq_rd), .enq_rd_we(enq_rd_we),
    .enq_aluop1_type(enq_aluop1_type), .enq_aluop2_type(enq_aluop2_type),
    .enq_imm(enq_imm), .enq_pc(enq_pc), .enq_aluctl(enq_aluctl),
    .iss_valid(iss_valid), .iss_ready(iss_ready),
    .iss_rs1(iss_rs1), .iss_rs2(iss_rs2), .iss_rd(iss_rd), .iss_rd_we(iss_rd_we),
    .iss_aluop1_type(iss_aluop1_type), .iss_aluop2_type(iss_aluop2_type),
    .iss_imm(iss_imm), .iss_pc(iss_pc), .iss_aluctl(iss_aluctl),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .count(count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic set_enq(input logic [14:0] pc, input logic [1:0] t1, input logic [4:0] rs1,
                         input logic [1:0] t2, input logic [4:0] rs2, input logic [4:0] rd,
                         input logic we, input logic [31:0] imm);
    enq_valid       = 1'b1;
    enq_pc          = pc;
    enq_aluop1_type = t1;
    enq_rs1         = rs1;
    enq_aluop2_type = t2;
    enq_rs2         = rs2;
    enq_rd          = rd;
    enq_rd_we       = we;
    enq_imm         = imm;
    enq_aluctl      = 5'(pc);
  endtask

  task automatic clr_enq();
    enq_valid = 1'b0;
  endtask

  // One clock: sample away from the edge, update the model, advance to the next negedge.
  task automatic tick();
    bit   acc;
    exp_t e;
    #1;
    check("enq_ready", 32'(enq_ready), 32'(model_cnt < DEPTH));
    acc = enq_valid && !flush && (model_cnt < DEPTH);
    if (flush) begin
      sb.delete();
      model_cnt = 0;
    end else begin
      if (iss_valid && iss_ready) begin
        if (sb.size() == 0) begin
          check("sb_underflow", 32'(sb.size()), 32'd1);
        end else begin
          e = sb.pop_front();
          check("iss_pc", 32'(iss_pc), 32'(e.pc));
          check("iss_imm", iss_imm, e.imm);
          check("iss_rd", 32'(iss_rd), 32'(e.rd));
          check("iss_aluctl", 32'(iss_aluctl), 32'(e.aluctl));
        end
        model_cnt--;
      end
      if (acc) begin
        sb.push_back('{pc: enq_pc, imm: enq_imm, rd: enq_rd, aluctl: enq_aluctl});
        model_cnt++;
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    // Reset and idle
    repeat (2) @(negedge clk);
    rst = 1'b0;
    tick();
    #1;
    check("rst_iss_valid", 32'(iss_valid), 32'd0);
    check("rst_enq_ready", 32'(enq_ready), 32'd1);
    check("rst_count", 32'(count), 32'd0);

    // ADDI x5: rs1 REG x1, imm 0x10
    iss_ready = 1'b1;
    set_enq(15'd1, T_REG, 5'd1, T_IMM, 5'd0, 5'd5, 1'b1, 32'h10);
    tick();
    clr_enq();
    #1;
    check("addi_valid", 32'(iss_valid), 32'd1);
    check("addi_imm", iss_imm, 32'h10);
    check("addi_rd", 32'(iss_rd), 32'd5);
    check("addi_count", 32'(count), 32'd1);
    tick();

    // ADD x6 = x5 + x2 stalls on busy x5 until writeback
    set_enq(15'd2, T_REG, 5'd5, T_REG, 5'd2, 5'd6, 1'b1, 32'h0);
    tick();
    clr_enq();
    #1;
    check("raw_stall0", 32'(iss_valid), 32'd0);
    tick();
    check("raw_stall1", 32'(iss_valid), 32'd0);
    wb_valid = 1'b1;
    wb_rd    = 5'd5;
    #1;
    check("wb_release", 32'(iss_valid), 32'd1);
    tick();
    wb_valid = 1'b0;
    #1;
    check("after_add_count", 32'(count), 32'd0);

    // Re-busy x5, then a PC/IMM op naming x5 must not stall
    set_enq(15'd3, T_IMM, 5'd0, T_IMM, 5'd0, 5'd5, 1'b1, 32'h33);
    tick();
    clr_enq();
    tick();
    set_enq(15'd4, T_PC, 5'd5, T_IMM, 5'd5, 5'd0, 1'b0, 32'h44);
    tick();
    clr_enq();
    #1;
    check("pc_no_stall", 32'(iss_valid), 32'd1);
    tick();

    // Fill to full with iss_ready low
    iss_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      set_enq(15'(10 + i), T_IMM, 5'd0, T_IMM, 5'd0, 5'd0, 1'b0, 32'(100 + i));
      tick();
    end
    clr_enq();
    #1;
    check("full_count", 32'(count), 32'd4);
    check("full_enq_ready", 32'(enq_ready), 32'd0);
    set_enq(15'd14, T_IMM, 5'd0, T_IMM, 5'd0, 5'd0, 1'b0, 32'd114);
    iss_ready = 1'b1;
    tick();
    check("full_refuse_count", 32'(count), 32'd3);
    for (int i = 0; i < 6; i++) begin
      set_enq(15'(15 + i), T_IMM, 5'd0, T_IMM, 5'd0, 5'd0, 1'b0, 32'(115 + i));
      tick();
    end
    clr_enq();
    check("wrap_count", 32'(count), 32'd3);
    repeat (3) tick();
    check("drain_count", 32'(count), 32'd0);

    // Flush with 3 queued and x7 busy
    set_enq(15'd30, T_IMM, 5'd0, T_IMM, 5'd0, 5'd7, 1'b1, 32'h30);
    tick();
    clr_enq();
    tick();
    iss_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      set_enq(15'(31 + i), T_IMM, 5'd0, T_IMM, 5'd0, 5'd0, 1'b0, 32'(131 + i));
      tick();
    end
    clr_enq();
    check("preflush_count", 32'(count), 32'd3);
    flush = 1'b1;
    set_enq(15'd34, T_IMM, 5'd0, T_IMM, 5'd0, 5'd0, 1'b0, 32'd134);
    #1;
    check("flush_iss_valid", 32'(iss_valid), 32'd0);
    tick();
    flush = 1'b0;
    clr_enq();
    #1;
    check("flush_count", 32'(count), 32'd0);
    check("flush_empty", 32'(iss_valid), 32'd0);
    iss_ready = 1'b1;
    set_enq(15'd35, T_REG, 5'd7, T_IMM, 5'd0, 5'd0, 1'b0, 32'h35);
    tick();
    clr_enq();
    #1;
    check("x7_still_busy0", 32'(iss_valid), 32'd0);
    tick();
    check("x7_still_busy1", 32'(iss_valid), 32'd0);
    wb_valid = 1'b1;
    wb_rd    = 5'd7;
    #1;
    check("x7_release", 32'(iss_valid), 32'd1);
    tick();
    wb_valid = 1'b0;

    // Asynchronous reset mid-queue (x6 is still busy from the ADD)
    iss_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      set_enq(15'(40 + i), T_IMM, 5'd0, T_IMM, 5'd0, 5'd0, 1'b0, 32'(140 + i));
      tick();
    end
    clr_enq();
    #1;
    check("pre_rst_count", 32'(count), 32'd3);
    check("pre_rst_valid", 32'(iss_valid), 32'd1);
    #1;
    rst = 1'b1;
    #1;
    check("async_rst_count", 32'(count), 32'd0);
    check("async_rst_valid", 32'(iss_valid), 32'd0);
    check("async_rst_ready", 32'(enq_ready), 32'd1);
    sb.delete();
    model_cnt = 0;
    @(negedge clk);
    rst = 1'b0;
    iss_ready = 1'b1;
    set_enq(15'd50, T_REG, 5'd6, T_IMM, 5'd0, 5'd0, 1'b0, 32'h50);
    tick();
    clr_enq();
    #1;
    check("busy_reset", 32'(iss_valid), 32'd1);
    tick();

    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
